vend_controller: RTL

- Top-level sequencer for the bottle vending machine.
- Accepts coins from two coin slots (A and B) and arbitrates them round-robin into one credit accumulator.
- Once credit reaches the price, it drives the bottle-drop pulse, pays out change as unit pulses, then unlocks the door and supervises door opening/closing with a timeout.
- Sits between the coin validators, the dispenser mechanics and the door lock.

---
 rtl/vend_controller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - bottle vending machine top-level sequencer
//
// Two coin slots are arbitrated round-robin into one credit accumulator.
// When credit reaches PRICE the bottle is dropped, change is paid out as unit
// pulses, and the door is unlocked and supervised until it closes or times out.
// A cancel while collecting refunds the credit through the same change path,
// without unlocking the door.
//
// Ports:
//   clk50m        system clock, rising edge
//   rst_n         asynchronous active-low reset
//   coin_a/b      coin value for slot A/B, valid with new_coin_a/b
//   new_coin_a/b  single-cycle coin strobe for slot A/B
//   door          1 = door open, 0 = closed
//   cancel        single-cycle refund request (honoured in COLLECT only)
//   bottle        bottle-drop drive, high for BOTTLE_CYC cycles per vend
//   unlock        door lock release level
//   change_pulse  one pulse per coin unit returned
//   coin_reject   one-cycle pulse after a coin that was not accepted
//   credit        current credit
//   busy          high in VEND, CHANGE and UNLOCK
module vend_controller #(
  parameter int PRICE        = 7,
  parameter int CREDIT_W     = 5,
  parameter int BOTTLE_CYC   = 4,
  parameter int CHANGE_GAP   = 2,
  parameter int DOOR_TIMEOUT = 1000
) (
  input  logic                clk50m,
  input  logic                rst_n,
  input  logic [3:0]          coin_a,
  input  logic                new_coin_a,
  input  logic [3:0]          coin_b,
  input  logic                new_coin_b,
  input  logic                door,
  input  logic                cancel,
  output logic                bottle,
  output logic                unlock,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE, S_UNLOCK} state_t;

  // One counter serves both the bottle hold time and the change pulse period.
  localparam int CNT_W = $clog2(BOTTLE_CYC + CHANGE_GAP + 1);
  localparam int TMR_W = $clog2(DOOR_TIMEOUT + 1);
  localparam logic [CREDIT_W:0]   MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                ptr_q, ptr_d;        // 0: A wins next contention, 1: B
  logic                refund_q, refund_d;
  logic                seen_q, seen_d;      // door has opened during this UNLOCK
  logic                reject_q, reject_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;

  logic                grant_a, grant_b, take_a, take_b;
  logic [CREDIT_W:0]   sum_a, sum_b;
  logic                fits_a, fits_b;

  // One extra bit on the sums so an overflowing coin is detected, not wrapped.
  assign sum_a  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_a);
  assign sum_b  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_b);
  assign fits_a = (coin_a != 4'd0) && (sum_a <= MAX_CREDIT);
  assign fits_b = (coin_b != 4'd0) && (sum_b <= MAX_CREDIT);

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      ptr_q    <= 1'b0;
      refund_q <= 1'b0;
      seen_q   <= 1'b0;
      reject_q <= 1'b0;
      cnt_q    <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      refund_q <= refund_d;
      seen_q   <= seen_d;
      reject_q <= reject_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    refund_d = refund_q;
    seen_d   = seen_q;
    reject_d = 1'b0;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    take_a   = 1'b0;
    take_b   = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (state_q == S_COLLECT && cancel) begin
          // Cancel beats any coin arriving in the same cycle.
          reject_d = new_coin_a | new_coin_b;
          refund_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_CHANGE;
        end else begin
          if (new_coin_a && new_coin_b) begin
            grant_a = ~ptr_q;
            grant_b = ptr_q;
            ptr_d   = ~ptr_q;
          end else begin
            grant_a = new_coin_a;
            grant_b = new_coin_b;
          end
          take_a   = grant_a & fits_a;
          take_b   = grant_b & fits_b;
          reject_d = (new_coin_a & ~take_a) | (new_coin_b & ~take_b);
          if (take_a) begin
            credit_d = sum_a[CREDIT_W-1:0];
          end else if (take_b) begin
            credit_d = sum_b[CREDIT_W-1:0];
          end
          if (take_a | take_b) begin
            cnt_d   = '0;
            state_d = (credit_d >= PRICE_C) ? S_VEND : S_COLLECT;
          end
        end
      end
      S_VEND: begin
        reject_d = new_coin_a | new_coin_b;
        if (cnt_q == CNT_W'(BOTTLE_CYC - 1)) begin
          credit_d = credit_q - PRICE_C;
          cnt_d    = '0;
          tmr_d    = '0;
          seen_d   = 1'b0;
          state_d  = (credit_q > PRICE_C) ? S_CHANGE : S_UNLOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHANGE: begin
        // cnt 0 is the high cycle of the pulse, 1..CHANGE_GAP is the gap.
        reject_d = new_coin_a | new_coin_b;
        if (cnt_q == '0) begin
          credit_d = credit_q - CREDIT_W'(1);
        end
        if (cnt_q == CNT_W'(CHANGE_GAP)) begin
          cnt_d = '0;
          if (credit_q == '0) begin
            if (refund_q) begin
              refund_d = 1'b0;
              state_d  = S_IDLE;
            end else begin
              tmr_d   = '0;
              seen_d  = 1'b0;
              state_d = S_UNLOCK;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_UNLOCK: begin
        // The timeout only runs while the door has never been opened.
        reject_d = new_coin_a | new_coin_b;
        if (door) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = S_IDLE;
        end else if (tmr_q == TMR_W'(DOOR_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bottle       = (state_q == S_VEND);
  assign unlock       = (state_q == S_UNLOCK);
  assign change_pulse = (state_q == S_CHANGE) && (cnt_q == '0);
  assign coin_reject  = reject_q;
  assign credit       = credit_q;
  assign busy         = (state_q == S_VEND) || (state_q == S_CHANGE) || (state_q == S_UNLOCK);

endmodule
